expmod_result_serializer: RTL

- Sits directly downstream of the modular-exponentiation engine.
- Captures each `WIDTH`-bit result on the engine's one-cycle valid pulse and holds it in a small FIFO.
- Serializes each word MSB-first into 8-bit beats on a valid/ready byte stream, which feeds the UART/display path.
- Decouples the engine's result rate from a slow byte consumer and flags dropped results.

---
 rtl/expmod_result_serializer.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/expmod_result_serializer.sv
`default_nettype none
// ============================================================================
// Module      : expmod_result_serializer
// Description : Captures WIDTH-bit results from the modular-exponentiation
//               engine into a small FIFO and serializes each word MSB-first
//               as 8-bit beats on a valid/ready byte stream. Results that
//               arrive with no FIFO space are dropped and flagged by a sticky
//               overflow bit.
//               Optional framing (macro EXPMOD_SERIALIZER_FRAME_EN): each word
//               is sent as 0xA5, the data bytes, then an XOR checksum byte.
// Revision    : 1.0 - initial release
// ============================================================================
module expmod_result_serializer #(
    parameter int WIDTH = 32,   // multiple of 8, minimum 8
    parameter int DEPTH = 4     // power of 2, minimum 2
) (
    input  logic                         clk_in,
    input  logic                         rst_n_in,
    input  logic [WIDTH-1:0]             value_in,
    input  logic                         valid_in,
    input  logic                         clear_overflow_in,
    output logic [7:0]                   byte_out,
    output logic                         byte_valid_out,
    input  logic                         byte_ready_in,
    output logic                         busy_out,
    output logic [$clog2(DEPTH+1)-1:0]   count_out,
    output logic                         overflow_out
);

    localparam int c_PTR_W   = $clog2(DEPTH);
    localparam int c_CNT_W   = $clog2(DEPTH + 1);
    localparam int c_NBYTES  = WIDTH / 8;
    localparam int c_BCNT_W  = $clog2(c_NBYTES + 1);

    localparam logic [c_CNT_W-1:0]  c_DEPTH_CNT  = c_CNT_W'(DEPTH);
    localparam logic [c_BCNT_W-1:0] c_NBYTES_CNT = c_BCNT_W'(c_NBYTES);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_SEND = 2'd1;
`ifdef EXPMOD_SERIALIZER_FRAME_EN
    localparam logic [1:0] c_ST_SYNC = 2'd2;
    localparam logic [1:0] c_ST_CSUM = 2'd3;
    localparam logic [7:0] c_SYNC_BYTE = 8'hA5;
`endif

    // FIFO storage and bookkeeping
    logic [WIDTH-1:0]    r_mem [DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;
    logic                r_overflow;

    // Serializer datapath
    logic [1:0]          r_state;
    logic [1:0]          w_next_state;
    logic [WIDTH-1:0]    r_shift;
    logic [c_BCNT_W-1:0] r_bytes_left;
`ifdef EXPMOD_SERIALIZER_FRAME_EN
    logic [7:0]          r_csum;
`endif

    logic w_pop;
    logic w_push;
    logic w_drop;
    logic w_fire;
    logic w_last_data;

    // The FSM only pops from IDLE; a full FIFO still has room when that pop
    // lands in the same cycle as the incoming result.
    assign w_pop       = (r_state == c_ST_IDLE) && (r_count != '0);
    assign w_push      = valid_in && ((r_count < c_DEPTH_CNT) || w_pop);
    assign w_drop      = valid_in && !w_push;
    assign w_fire      = byte_valid_out && byte_ready_in;
    assign w_last_data = (r_bytes_left == c_BCNT_W'(1));

    assign busy_out     = (r_state != c_ST_IDLE) || (r_count != '0);
    assign count_out    = r_count;
    assign overflow_out = r_overflow;

    // FIFO data write; contents are don't-care until the pointers say otherwise
    always_ff @(posedge clk_in) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= value_in;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally as DEPTH is 2^n
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky overflow flag; a drop in the same cycle as a clear keeps it set
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (clear_overflow_in) begin
            r_overflow <= 1'b0;
        end
    end

    // FSM state register
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_pop) begin
`ifdef EXPMOD_SERIALIZER_FRAME_EN
                    w_next_state = c_ST_SYNC;
`else
                    w_next_state = c_ST_SEND;
`endif
                end
            end
`ifdef EXPMOD_SERIALIZER_FRAME_EN
            c_ST_SYNC: begin
                if (w_fire) begin
                    w_next_state = c_ST_SEND;
                end
            end
            c_ST_SEND: begin
                if (w_fire && w_last_data) begin
                    w_next_state = c_ST_CSUM;
                end
            end
            c_ST_CSUM: begin
                if (w_fire) begin
                    w_next_state = c_ST_IDLE;
                end
            end
`else
            c_ST_SEND: begin
                if (w_fire && w_last_data) begin
                    w_next_state = c_ST_IDLE;
                end
            end
`endif
            default: w_next_state = c_ST_IDLE;
        endcase
    end

    // FSM outputs: purely a function of registered state, never of ready
    always_comb begin
        byte_valid_out = (r_state != c_ST_IDLE);
        byte_out       = 8'h00;
        case (r_state)
            c_ST_SEND: byte_out = r_shift[WIDTH-1 -: 8];
`ifdef EXPMOD_SERIALIZER_FRAME_EN
            c_ST_SYNC: byte_out = c_SYNC_BYTE;
            c_ST_CSUM: byte_out = r_csum;
`endif
            default:   byte_out = 8'h00;
        endcase
    end

    // Shift register and byte counter: load on pop, advance on each data handshake
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_shift      <= '0;
            r_bytes_left <= '0;
        end else if (w_pop) begin
            r_shift      <= r_mem[r_rd_ptr];
            r_bytes_left <= c_NBYTES_CNT;
        end else if ((r_state == c_ST_SEND) && w_fire) begin
            r_shift      <= r_shift << 8;
            r_bytes_left <= r_bytes_left - 1'b1;
        end
    end

`ifdef EXPMOD_SERIALIZER_FRAME_EN
    // Running XOR of the data bytes actually handed to the consumer
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_csum <= 8'h00;
        end else if (w_pop) begin
            r_csum <= 8'h00;
        end else if ((r_state == c_ST_SEND) && w_fire) begin
            r_csum <= r_csum ^ r_shift[WIDTH-1 -: 8];
        end
    end
`endif

endmodule
`default_nettype wire
